// File: rtl/wb_shared_intercon.sv
// Shared-bus WISHBONE classic interconnect: N masters, M slaves, round-robin arbitration, base/mask decode.
// Optional stalled-cycle watchdog is built when INTERCON_TIMEOUT_EN is defined.
module wb_shared_intercon #(
    parameter int NUM_MASTERS    = 4,
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_WIDTH     = 22,
    parameter int DATA_WIDTH     = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
        {22'h003000, 22'h002000, 22'h001000, 22'h000000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
        {22'h000FFF, 22'h000FFF, 22'h000FFF, 22'h000FFF},
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_MASTERS-1:0]             m_cyc_i,
    input  logic [NUM_MASTERS-1:0]             m_stb_i,
    input  logic [NUM_MASTERS-1:0]             m_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_dat_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
    output logic [NUM_MASTERS-1:0]             m_ack_o,
    output logic [NUM_MASTERS-1:0]             m_err_o,
    output logic [NUM_MASTERS-1:0]             m_rty_o,
    output logic [DATA_WIDTH-1:0]              m_dat_o,
    output logic [NUM_SLAVES-1:0]              s_cyc_o,
    output logic [NUM_SLAVES-1:0]              s_stb_o,
    output logic                               s_we_o,
    output logic [NUM_SLAVES*ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]              s_dat_o,
    output logic [DATA_WIDTH/8-1:0]            s_sel_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   s_dat_i,
    input  logic [NUM_SLAVES-1:0]              s_ack_i,
    input  logic [NUM_SLAVES-1:0]              s_err_i,
    input  logic [NUM_SLAVES-1:0]              s_rty_i,
    output logic                               bus_err_o,
    output logic [ADDR_WIDTH-1:0]              err_adr_o,
    output logic [1:0]                         err_code_o
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {ST_IDLE, ST_OWNED} state_t;

    state_t                  r_state, w_state_nxt;
    logic [NUM_MASTERS-1:0]  r_gnt, w_gnt_nxt;
    logic [PTR_W-1:0]        r_ptr, w_ptr_nxt;

    logic                    w_cyc, w_stb, w_we, w_stb_act;
    logic [ADDR_WIDTH-1:0]   w_adr;
    logic [DATA_WIDTH-1:0]   w_wdat, w_rdat;
    logic [SEL_W-1:0]        w_sel;
    logic [NUM_SLAVES-1:0]   w_hit;
    logic                    w_any, w_s_ack, w_s_err, w_s_rty, w_term;
    logic                    w_timeout, w_dec_set;

    logic                    r_err_pend, r_bus_err;
    logic [ADDR_WIDTH-1:0]   r_err_adr;
    logic [1:0]              r_err_code;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ptr   <= PTR_W'(NUM_MASTERS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Round robin: first pass takes requesters above ptr, second pass wraps to the bottom.
    always_comb begin
        logic found;
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        found       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (!found && m_cyc_i[i] && (i > int'(r_ptr))) begin
                        found        = 1'b1;
                        w_gnt_nxt    = '0;
                        w_gnt_nxt[i] = 1'b1;
                        w_ptr_nxt    = PTR_W'(i);
                    end
                end
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (!found && m_cyc_i[i]) begin
                        found        = 1'b1;
                        w_gnt_nxt    = '0;
                        w_gnt_nxt[i] = 1'b1;
                        w_ptr_nxt    = PTR_W'(i);
                    end
                end
                if (found) w_state_nxt = ST_OWNED;
            end
            ST_OWNED: begin
                if ((m_cyc_i & r_gnt) == '0) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        logic found;
        w_cyc  = 1'b0;
        w_stb  = 1'b0;
        w_we   = 1'b0;
        w_adr  = '0;
        w_wdat = '0;
        w_sel  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_cyc  |= m_cyc_i[i] & r_gnt[i];
            w_stb  |= m_stb_i[i] & r_gnt[i];
            w_we   |= m_we_i[i]  & r_gnt[i];
            w_adr  |= m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{r_gnt[i]}};
            w_wdat |= m_dat_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{r_gnt[i]}};
            w_sel  |= m_sel_i[i*SEL_W +: SEL_W] & {SEL_W{r_gnt[i]}};
        end
        found  = 1'b0;
        w_hit  = '0;
        w_rdat = '0;
        for (int j = 0; j < NUM_SLAVES; j++) begin
            if (!found && w_cyc &&
                ((w_adr & ~SLAVE_MASK[j*ADDR_WIDTH +: ADDR_WIDTH]) ==
                 SLAVE_BASE[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
                found    = 1'b1;
                w_hit[j] = 1'b1;
            end
            w_rdat |= s_dat_i[j*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{w_hit[j]}};
        end
    end

    assign w_any     = |w_hit;
    assign w_stb_act = w_cyc & w_stb;
    assign w_s_ack   = |(s_ack_i & w_hit);
    assign w_s_err   = |(s_err_i & w_hit);
    assign w_s_rty   = |(s_rty_i & w_hit);
    assign w_term    = w_s_ack | w_s_err | w_s_rty | r_err_pend;
    assign w_dec_set = w_stb_act & ~w_any & ~r_err_pend;

`ifdef INTERCON_TIMEOUT_EN
    logic [15:0] r_wdog;

    assign w_timeout = w_stb_act & ~w_term & (r_wdog == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                  r_wdog <= '0;
        else if (w_stb_act && !w_term && !w_timeout) r_wdog <= r_wdog + 16'd1;
        else                                        r_wdog <= '0;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_pend <= 1'b0;
            r_bus_err  <= 1'b0;
            r_err_adr  <= '0;
            r_err_code <= 2'b00;
        end else begin
            r_err_pend <= w_dec_set;
            r_bus_err  <= w_dec_set | w_timeout;
            if (w_dec_set) begin
                r_err_adr  <= w_adr;
                r_err_code <= 2'b01;
            end else if (w_timeout) begin
                r_err_adr  <= w_adr;
                r_err_code <= 2'b10;
            end
        end
    end

    // A watchdog expiry pulls the slave strobes so a late ack cannot land on the next cycle.
    assign s_cyc_o = {NUM_SLAVES{w_cyc & ~w_timeout}} & w_hit;
    assign s_stb_o = {NUM_SLAVES{w_stb & ~w_timeout}} & w_hit;
    assign s_we_o  = w_we;
    assign s_dat_o = w_wdat;
    assign s_sel_o = w_sel;

    always_comb begin
        for (int j = 0; j < NUM_SLAVES; j++)
            s_adr_o[j*ADDR_WIDTH +: ADDR_WIDTH] = w_adr & SLAVE_MASK[j*ADDR_WIDTH +: ADDR_WIDTH];
    end

    assign m_ack_o    = r_gnt & {NUM_MASTERS{w_s_ack}};
    assign m_err_o    = r_gnt & {NUM_MASTERS{w_s_err | r_err_pend | w_timeout}};
    assign m_rty_o    = r_gnt & {NUM_MASTERS{w_s_rty}};
    assign m_dat_o    = w_rdat;
    assign bus_err_o  = r_bus_err;
    assign err_adr_o  = r_err_adr;
    assign err_code_o = r_err_code;

endmodule
